// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the NUM_REQ requesters, the arbiter and the regfile write port.
// Requesters drive the req_* group; the arbiter returns req_ready and drives the regfile write port.
interface regfile_wb_arbiter_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SEL   = 5,
    parameter int NUM_REQ   = 3
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*REG_SEL-1:0]   req_sel;
    logic [NUM_REQ*WORD_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         wCtrl;
    logic [REG_SEL-1:0]           wSel;
    logic [WORD_SIZE-1:0]         wData;

    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, wCtrl, wSel, wData
    );

    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, wCtrl, wSel, wData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, plus a per-register pending
// scoreboard that lets decode stall on outstanding writebacks.
module regfile_wb_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int NUM_REQ   = 3,
    parameter int CNT_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 issue_valid,
    input  logic [REG_SEL-1:0]   issue_rd,
    input  logic [REG_SEL-1:0]   rs1,
    input  logic [REG_SEL-1:0]   rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [CNT_W-1:0]     pending_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 wctrl_q, wctrl_d;
    logic [REG_SEL-1:0]   wsel_q, wsel_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]     pending_cnt_q, pending_cnt_d;

    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 transfer;
    logic [REG_SEL-1:0]   sel_g;
    logic [WORD_SIZE-1:0] data_g;
    int                   idx;

    // Search starts at rr_ptr and wraps; grants are suppressed while in reset or on hold.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        transfer  = 1'b0;
        sel_g     = '0;
        data_g    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!transfer && rst && !hold && wb.req_valid[idx]) begin
                transfer   = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                sel_g      = wb.req_sel[idx*REG_SEL +: REG_SEL];
                data_g     = wb.req_data[idx*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wctrl_d  = 1'b0;
        wsel_d   = '0;
        wdata_d  = '0;
        if (transfer) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            wctrl_d  = (sel_g != '0);
            wsel_d   = sel_g;
            wdata_d  = data_g;
        end
    end

    logic                set_act, clr_act, set_hit, clr_hit;
    logic [NUM_REGS-1:0] set_vec, clr_vec;

    // A set on the register being committed this edge wins over the clear.
    always_comb begin
        set_act = issue_valid && (issue_rd != '0);
        clr_act = wctrl_q;
        set_vec = '0;
        clr_vec = '0;
        if (set_act) set_vec[issue_rd] = 1'b1;
        if (clr_act) clr_vec[wsel_q]   = 1'b1;
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
        set_hit = set_act && !pending_q[issue_rd];
        clr_hit = clr_act && pending_q[wsel_q] && !(set_act && (issue_rd == wsel_q));
        pending_cnt_d = pending_cnt_q + CNT_W'(set_hit) - CNT_W'(clr_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            wctrl_q       <= 1'b0;
            wsel_q        <= '0;
            wdata_q       <= '0;
            pending_q     <= '0;
            pending_cnt_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wctrl_q       <= wctrl_d;
            wsel_q        <= wsel_d;
            wdata_q       <= wdata_d;
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign wb.req_ready = grant;
    assign wb.wCtrl     = wctrl_q;
    assign wb.wSel      = wsel_q;
    assign wb.wData     = wdata_q;
    assign rs1_busy     = pending_q[rs1];
    assign rs2_busy     = pending_q[rs2];
    assign pending_cnt  = pending_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, output latency and scoreboard.
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_busy;
    logic       rs2_busy;
    logic [5:0] pending_cnt;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter_if #(.WORD_SIZE(32), .REG_SEL(5), .NUM_REQ(3)) wb ();

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] sel, input logic [31:0] data);
        wb.req_sel[i*5 +: 5]    = sel;
        wb.req_data[i*32 +: 32] = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wb.req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1111_1111);
        set_req(1, 5'd2, 32'h2222_2222);
        set_req(2, 5'd3, 32'h3333_3333);
        tick();
        tick();
        checks++; if (wb.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", wb.req_ready); end
        checks++; if (wb.wCtrl !== 1'b0) begin errors++; $display("FAIL reset_wctrl: got %b exp 0", wb.wCtrl); end
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", pending_cnt); end
        rst = 1'b1;
        wb.req_valid = 3'b001;
        set_req(0, 5'd0, 32'h8765_4321);
        #1;
        checks++; if (wb.req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b exp 001", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        checks++; if (wb.wCtrl !== 1'b0) begin errors++; $display("FAIL x0_wctrl: got %b exp 0", wb.wCtrl); end
        checks++; if (wb.wData !== 32'h8765_4321) begin errors++; $display("FAIL x0_wdata: got %h exp 87654321", wb.wData); end
    endtask

    // rr_ptr is 1 on entry; requester 1 wins and the pointer moves to 2.
    task automatic test_single();
        wb.req_valid = 3'b010;
        set_req(1, 5'd12, 32'hDEAD_BEEF);
        #1;
        checks++; if (wb.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b exp 010", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        checks++; if (wb.wCtrl !== 1'b1) begin errors++; $display("FAIL single_wctrl: got %b exp 1", wb.wCtrl); end
        checks++; if (wb.wSel !== 5'd12) begin errors++; $display("FAIL single_wsel: got %0d exp 12", wb.wSel); end
        checks++; if (wb.wData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h exp deadbeef", wb.wData); end
        tick();
        checks++; if (wb.wCtrl !== 1'b0) begin errors++; $display("FAIL single_idle_wctrl: got %b exp 0", wb.wCtrl); end
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL single_unpending_cnt: got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_back_to_back();
        // A requester-2 x0 write brings rr_ptr from 2 back to 0.
        wb.req_valid = 3'b100;
        set_req(2, 5'd0, 32'h0);
        #1;
        checks++; if (wb.req_ready !== 3'b100) begin errors++; $display("FAIL rr_align_ready: got %b exp 100", wb.req_ready); end
        tick();
        wb.req_valid = 3'b111;
        set_req(0, 5'd3,  32'hA000_0003);
        set_req(1, 5'd16, 32'hA000_0016);
        set_req(2, 5'd31, 32'hA000_0031);
        #1;
        checks++; if (wb.req_ready !== 3'b001) begin errors++; $display("FAIL rr_grant0: got %b exp 001", wb.req_ready); end
        tick();
        checks++; if (wb.wSel !== 5'd3 || wb.wCtrl !== 1'b1) begin errors++; $display("FAIL rr_wsel0: got %0d/%b exp 3/1", wb.wSel, wb.wCtrl); end
        checks++; if (wb.req_ready !== 3'b010) begin errors++; $display("FAIL rr_grant1: got %b exp 010", wb.req_ready); end
        tick();
        checks++; if (wb.wSel !== 5'd16 || wb.wCtrl !== 1'b1) begin errors++; $display("FAIL rr_wsel1: got %0d/%b exp 16/1", wb.wSel, wb.wCtrl); end
        checks++; if (wb.req_ready !== 3'b100) begin errors++; $display("FAIL rr_grant2: got %b exp 100", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        checks++; if (wb.wSel !== 5'd31 || wb.wData !== 32'hA000_0031) begin errors++; $display("FAIL rr_wsel2: got %0d/%h exp 31/a0000031", wb.wSel, wb.wData); end
        tick();
    endtask

    task automatic test_hold();
        hold = 1'b1;
        wb.req_valid = 3'b101;
        set_req(0, 5'd9,  32'h0000_0009);
        set_req(2, 5'd10, 32'h0000_000A);
        #1;
        checks++; if (wb.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready: got %b exp 000", wb.req_ready); end
        tick();
        checks++; if (wb.wCtrl !== 1'b0 || wb.req_ready !== 3'b000) begin errors++; $display("FAIL hold_held: got %b/%b exp 0/000", wb.wCtrl, wb.req_ready); end
        hold = 1'b0;
        #1;
        checks++; if (wb.req_ready !== 3'b001) begin errors++; $display("FAIL hold_release_ready: got %b exp 001", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        checks++; if (wb.wSel !== 5'd9 || wb.wCtrl !== 1'b1) begin errors++; $display("FAIL hold_release_wsel: got %0d/%b exp 9/1", wb.wSel, wb.wCtrl); end
        tick();
    endtask

    // rr_ptr is 1 on entry, so requester 2 wins the x5 write.
    task automatic test_scoreboard();
        rs1 = 5'd5;
        rs2 = 5'd6;
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_pre_busy: got %b exp 0", rs1_busy); end
        tick();
        issue_valid = 1'b0;
        checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_busy: got %b/%b exp 1/0", rs1_busy, rs2_busy); end
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_set: got %0d exp 1", pending_cnt); end
        wb.req_valid = 3'b100;
        set_req(2, 5'd5, 32'h0101_0101);
        #1;
        checks++; if (wb.req_ready !== 3'b100) begin errors++; $display("FAIL sb_ready: got %b exp 100", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        checks++; if (wb.wCtrl !== 1'b1 || wb.wSel !== 5'd5 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_commit_cycle: got %b/%0d/%b exp 1/5/1", wb.wCtrl, wb.wSel, rs1_busy); end
        tick();
        checks++; if (rs1_busy !== 1'b0 || pending_cnt !== 6'd0) begin errors++; $display("FAIL sb_cleared: got %b/%0d exp 0/0", rs1_busy, pending_cnt); end
    endtask

    // rr_ptr is 0 on entry.
    task automatic test_set_clear();
        rs1 = 5'd7;
        rs2 = 5'd9;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_cnt_pre: got %0d exp 1", pending_cnt); end
        wb.req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_0077);
        tick();
        wb.req_valid = 3'b000;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        checks++; if (rs1_busy !== 1'b1 || pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_set_wins: got %b/%0d exp 1/1", rs1_busy, pending_cnt); end
        rs2 = 5'd0;
        issue_valid = 1'b1;
        issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        checks++; if (rs2_busy !== 1'b0 || pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_x0_issue: got %b/%0d exp 0/1", rs2_busy, pending_cnt); end
        // Clear of x7 coincides with a set of x9: count stays at 1.
        rs2 = 5'd9;
        wb.req_valid = 3'b001;
        tick();
        wb.req_valid = 3'b000;
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1 || pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_net_zero: got %b/%b/%0d exp 0/1/1", rs1_busy, rs2_busy, pending_cnt); end
    endtask

    task automatic test_reset_mid();
        wb.req_valid = 3'b010;
        set_req(1, 5'd4, 32'h0000_0044);
        rst = 1'b0;
        #1;
        checks++; if (wb.req_ready !== 3'b000) begin errors++; $display("FAIL mid_reset_ready: got %b exp 000", wb.req_ready); end
        tick();
        checks++; if (wb.wCtrl !== 1'b0 || pending_cnt !== 6'd0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got %b/%0d/%b exp 0/0/0", wb.wCtrl, pending_cnt, rs2_busy); end
        rst = 1'b1;
        wb.req_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        hold = 1'b0;
        issue_valid = 1'b0;
        issue_rd = '0;
        rs1 = '0;
        rs2 = '0;
        wb.req_valid = '0;
        wb.req_sel = '0;
        wb.req_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_scoreboard();
        test_set_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
